// File: rtl/acc_buf_pkg.sv
// Shared sizing helpers and parameter checks for the multiplier-to-accumulator
// elastic buffer (mul_acc_buffer_fifo and acc_buf_ram).
package acc_buf_pkg;

  // Pointer width: log2 of the entry count, at least 1 bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Power-of-two check used for DEPTH; pointers rely on natural wrap.
  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  // almost_full threshold must lie within 1..depth.
  function automatic bit afull_ok(input int lvl, input int depth);
    return (lvl >= 1) && (lvl <= depth);
  endfunction

  // Bit offset of a lane inside a packed entry; lane 0 sits at the LSBs.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/acc_buf_ram.sv
// DEPTH x (WIDTH*LANES) storage for the accumulator buffer.
// One synchronous write port, one asynchronous read port, no reset on the array.
module acc_buf_ram
  import acc_buf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 1,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [PW-1:0]            wr_addr_i,
  input  logic [WIDTH*LANES-1:0]   wr_data_i,
  input  logic [PW-1:0]            rd_addr_i,
  output logic [WIDTH*LANES-1:0]   rd_data_o
);

  logic [WIDTH*LANES-1:0] mem_q [DEPTH];

  // Write all lanes of the addressed entry together.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int l = 0; l < LANES; l++) begin
        mem_q[wr_addr_i][lane_lsb(l, WIDTH) +: WIDTH] <= wr_data_i[lane_lsb(l, WIDTH) +: WIDTH];
      end
    end
  end

  // Head entry is visible in the same cycle its address is presented.
  always_comb begin
    rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/mul_acc_buffer_fifo.sv
// Elastic FIFO between the multiplier array and the accumulator.
// First-word fall-through from registered storage; full/empty derived from count.
// Optional sticky overflow flag (err_ovf / err_clr) when ACC_BUF_ERR_EN is defined.
module mul_acc_buffer_fifo
  import acc_buf_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                        clk,
  input  logic                        rst_sync,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [WIDTH*LANES-1:0]      in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [WIDTH*LANES-1:0]      out_data,
  input  logic                        out_ready,
  output logic [cnt_w(DEPTH)-1:0]     count,
  output logic                        almost_full
`ifdef ACC_BUF_ERR_EN
  ,
  input  logic                        err_clr,
  output logic                        err_ovf
`endif
);

  localparam int DW = WIDTH * LANES;
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("mul_acc_buffer_fifo: DEPTH must be a power of two >= 2");
  end
  if (!afull_ok(AFULL_LVL, DEPTH)) begin : g_bad_afull
    $error("mul_acc_buffer_fifo: AFULL_LVL must be within 1..DEPTH");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push, pop, wr_en;
  logic [DW-1:0] head_data;

  // Handshake and status decode; all of it depends on registered state only.
  always_comb begin
    in_ready    = (count_q != CW'(DEPTH));
    out_valid   = (count_q != '0);
    push        = in_valid & in_ready;
    pop         = out_valid & out_ready;
    wr_en       = push & ~flush & ~rst_sync;
    out_data    = out_valid ? head_data : '0;
    count       = count_q;
    almost_full = (count_q >= CW'(AFULL_LVL));
  end

  // Next-state for pointers and occupancy; flush outranks traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef ACC_BUF_ERR_EN
  logic err_ovf_q, err_ovf_d;

  // Sticky overflow: a dropped push sets it, err_clr clears it, set wins.
  always_comb begin
    err_ovf_d = err_ovf_q;
    if (in_valid & ~in_ready) err_ovf_d = 1'b1;
    else if (err_clr)         err_ovf_d = 1'b0;
  end

  // Overflow flag register; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst_sync) err_ovf_q <= 1'b0;
    else          err_ovf_q <= err_ovf_d;
  end

  assign err_ovf = err_ovf_q;
`endif

  acc_buf_ram #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_data),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_data)
  );

endmodule

// File: tb/tb_mul_acc_buffer_fifo.sv
// Self-checking bench for mul_acc_buffer_fifo (WIDTH=8, LANES=2, DEPTH=4).
// Expected head data comes from a scoreboard queue filled as pushes are driven.
module tb_mul_acc_buffer_fifo;

  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int DW    = WIDTH * LANES;

  logic          clk = 1'b0;
  logic          rst_sync = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [2:0]    count;
  logic          almost_full;
`ifdef ACC_BUF_ERR_EN
  logic          err_clr = 1'b0;
  logic          err_ovf;
`endif

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  bit            merr = 1'b0;

  always #5 clk = ~clk;

  mul_acc_buffer_fifo #(
    .WIDTH     (WIDTH),
    .LANES     (LANES),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL)
  ) dut (
    .clk         (clk),
    .rst_sync    (rst_sync),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full)
`ifdef ACC_BUF_ERR_EN
    ,
    .err_clr     (err_clr),
    .err_ovf     (err_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl, input bit ec);
    int n;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
`ifdef ACC_BUF_ERR_EN
    err_clr   = ec;
`endif
    n = exp_q.size();
    chk("in_ready",    32'(in_ready),    32'(n != DEPTH));
    chk("out_valid",   32'(out_valid),   32'(n != 0));
    chk("count",       32'(count),       32'(n));
    chk("almost_full", 32'(almost_full), 32'(n >= AFULL));
    chk("out_data",    32'(out_data),    (n != 0) ? 32'(exp_q[0]) : 32'h0);
`ifdef ACC_BUF_ERR_EN
    chk("err_ovf",     32'(err_ovf),     32'(merr));
    if (iv && n == DEPTH) merr = 1'b1;
    else if (ec)          merr = 1'b0;
`endif
    if (fl) begin
      exp_q.delete();
    end else begin
      if (n != 0 && ordy)   void'(exp_q.pop_front());
      if (iv && n != DEPTH) exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_sync = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_sync = 1'b0;
    exp_q.delete();
    merr = 1'b0;
  endtask

  initial begin
    // Reset and idle.
    do_reset(2);
    cycle(0, '0, 0, 0, 0);

    // Fill with accumulator stalled, then drain in order.
    cycle(1, 16'h0102, 0, 0, 0);
    cycle(1, 16'h0304, 0, 0, 0);
    cycle(1, 16'h0506, 0, 0, 0);
    cycle(1, 16'h0708, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0, 0);

    // Concurrent push/pop at count=2; pointers wrap repeatedly.
    cycle(1, 16'h1000, 0, 0, 0);
    cycle(1, 16'h1001, 0, 0, 0);
    for (int i = 2; i < 12; i++) cycle(1, 16'h1000 + 16'(i), 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0, 0);

    // Full with pop: the push is dropped, then accepted next cycle.
    for (int i = 0; i < 4; i++) cycle(1, 16'h2000 + 16'(i), 0, 0, 0);
    cycle(1, 16'hAAAA, 1, 0, 0);
    cycle(1, 16'hAAAA, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0, 0);

    // Flush mid-stream with a concurrent push; overflow flag survives flush.
    for (int i = 0; i < 3; i++) cycle(1, 16'h3000 + 16'(i), 0, 0, 0);
    cycle(1, 16'h2222, 0, 1, 0);
    cycle(0, '0, 0, 0, 0);
    cycle(1, 16'h1111, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 0, 0, 0);

    // Clear the overflow flag, then clear and overflow together.
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 16'h4000 + 16'(i), 0, 0, 0);
    cycle(1, 16'hBBBB, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);

    // Reset mid-stream: nothing survives, next push lands cleanly.
    do_reset(1);
    cycle(0, '0, 0, 0, 0);
    cycle(1, 16'h3333, 0, 0, 0);
    cycle(1, 16'h4444, 1, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_acc_buffer_fifo.md
Name: mul_acc_buffer_fifo

Overview:
Parametrised, multi-lane elastic buffer between the multiplier array and the accumulator in the Euler datapath. It replaces the single-register multiplier-to-accumulator stage with a DEPTH-entry FIFO carrying LANES data words plus a valid/ready handshake. This lets the accumulator stall without losing multiplier results. It also provides occupancy, almost-full and flush.

Parameters:
WIDTH, 8, bits per lane word
LANES, 1, parallel lanes moved together as one entry
DEPTH, 4, entries; power of two, >= 2
AFULL_LVL, 3, almost_full asserts when count >= AFULL_LVL; range 1..DEPTH

Ports:
clk  in  1  rising-edge clock, sole clock
rst_sync  in  1  synchronous reset, active-high
flush  in  1  synchronous clear of contents, active-high
in_valid  in  1  multiplier done/valid for the entry on in_data
in_data  in  WIDTH*LANES  lane 0 in bits [WIDTH-1:0]
in_ready  out  1  buffer can accept an entry
out_valid  out  1  head entry available
out_data  out  WIDTH*LANES  head entry
out_ready  in  1  accumulator consumes head this cycle
count  out  $clog2(DEPTH+1)  current occupancy 0..DEPTH
almost_full  out  1  count >= AFULL_LVL

Behaviour:
- Clock and reset: all state updates on posedge clk. Reset is synchronous, active-high; there is no asynchronous reset.
- Reset values: count=0, pointers=0, out_valid=0, out_data=0, in_ready=1, almost_full=0.
- Priority per edge: rst_sync > flush > push/pop.
- in_ready = (count != DEPTH). It depends only on state; there is no combinational path from out_ready.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- out_valid = (count != 0). When count==0, out_data is forced to 0; otherwise out_data is the head entry (first-word fall-through from registered storage).
- Latency: an entry pushed at edge N is presented with out_valid=1 after edge N. Minimum in-to-out latency is 1 cycle.
- Simultaneous push and pop, count between 1 and DEPTH-1: both occur and count is unchanged.
- Empty: pop cannot occur; a push makes count=1.
- Full: in_ready=0, so in_valid is dropped even if out_ready=1 in the same cycle. A pop while full frees the slot for the next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is derived from count, not from pointer equality.
- flush: count, rd_ptr and wr_ptr go to 0; out_valid=0 next cycle. An in_valid in the same cycle is discarded. Storage contents need not be cleared.
- Reset or flush mid-stream: no partial entries survive. The next push after release lands at slot 0.
- Lanes are opaque: no per-lane arithmetic, and all lanes move atomically.

Optional Feature:
Macro: ACC_BUF_ERR_EN
- With it: adds output err_ovf (1 bit) and input err_clr (1 bit).
  - err_ovf is a sticky flag set on any edge where in_valid=1 and in_ready=0. This covers the multiplier issuing a result it cannot hold back.
  - err_ovf is cleared by rst_sync or err_clr. Set wins over err_clr in the same cycle.
  - flush does not clear err_ovf.
- Without it: neither port exists; dropped pushes are silent.

Decomposition:
- Package acc_buf_pkg:
  - ptr_w/cnt_w width functions (clog2-based)
  - lane-slicing helper constants
  - localparam checks: DEPTH power of two, AFULL_LVL range
- Sub-module acc_buf_ram: DEPTH x (WIDTH*LANES) register array.
  - One write port: wr_en, wr_addr, wr_data.
  - One asynchronous read port.
  - No reset on the array.
- Top level holds pointers, count, handshake and flags.

Test Plan:
- Reset/idle: rst_sync=1 for 2 cycles -> count=0, out_valid=0, out_data=0, in_ready=1, almost_full=0.
- Fill and drain, WIDTH=8, LANES=2, DEPTH=4, out_ready=0:
  - Push 0x0102, 0x0304, 0x0506, 0x0708 -> count=4, in_ready=0, almost_full=1 from count=3.
  - Then out_ready=1 -> outputs appear in order, one per cycle, and count returns to 0.
- Concurrent traffic: count=2, in_valid=1 and out_ready=1 for 10 cycles -> count stays 2; output sequence equals input sequence delayed by 2 entries; pointers wrap past slot 3 without error.
- Full with pop: count=4, in_valid=1 (0xAAAA), out_ready=1 -> head popped, 0xAAAA dropped, count=3. Next cycle 0xAAAA is accepted.
- Flush mid-stream: count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0. A later push of 0x1111 is output as 0x1111.
- ACC_BUF_ERR_EN:
  - Overflow push while full -> err_ovf=1 and holds through a flush.
  - err_clr=1 -> err_ovf=0 next cycle.
  - err_clr and an overflow in the same cycle -> err_ovf=1.
